// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the branch predict unit:
//   - RV32 conditional-branch funct3 encodings
//   - bp_state_t : table sweep state (INIT while clearing the BHT, RUN after)
//   - cnt_init_value() : weakly-not-taken value for a CNT_W-bit counter
// No ports (package).
// ---------------------------------------------------------------------------
package bp_pkg;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic {
      INIT,
      RUN
   } bp_state_t;

   // Weakly-not-taken sits just below the MSB threshold: 2^(w-1) - 1.
   function automatic int unsigned cnt_init_value(input int unsigned cnt_w);
      return (32'd1 << (cnt_w - 32'd1)) - 32'd1;
   endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// ---------------------------------------------------------------------------
// branch_cond_eval
// Pure combinational branch decision from funct3 and the ALU zero flag.
// The ALU compare is arranged so that BEQ/BGE/BGEU take on zero and
// BNE/BLT/BLTU take on not-zero; funct3 010/011 are not branches.
// Ports:
//   b        in  1  valid conditional branch in EX
//   funct3   in  3  branch funct3
//   zero     in  1  ALU zero flag
//   taken    out 1  resolved direction
//   illegal  out 1  b with an unsupported funct3
// ---------------------------------------------------------------------------
module branch_cond_eval
   import bp_pkg::*;
(
   input  logic       b,
   input  logic [2:0] funct3,
   input  logic       zero,
   output logic       taken,
   output logic       illegal
);

   // Decode funct3 into a direction; anything outside the six branch
   // encodings is flagged illegal and never taken.
   always_comb begin
      taken   = 1'b0;
      illegal = 1'b0;
      case (funct3)
         F3_BEQ, F3_BGE, F3_BGEU: taken   = b & zero;
         F3_BNE, F3_BLT, F3_BLTU: taken   = b & ~zero;
         default:                 illegal = b;
      endcase
   end

endmodule

// File: rtl/branch_predict_unit.sv
// ---------------------------------------------------------------------------
// branch_predict_unit
// Resolves conditional branches in EX, predicts direction at fetch from a
// PC-indexed table of saturating counters, flags mispredictions one cycle
// after resolution, and trains the table.
// After rst the table is swept to weakly-not-taken, one entry per cycle
// (INIT); predictions and training only happen once the sweep is done (RUN).
// Optional feature macro: BRANCH_PREDICT_STATS_EN adds stat_branches and
// stat_mispredicts saturating event counters.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   ready             out  table initialised
//   f_req, f_pc       in   fetch lookup request and PC
//   f_pred_valid      out  registered: lookup issued last cycle in RUN
//   f_pred_taken      out  registered: counter MSB of the looked-up entry
//   ex_valid, ex_branch, ex_funct3, ex_zero, ex_pc, ex_pred_taken  in  EX info
//   ex_taken, ex_illegal   out  combinational resolution
//   mispredict        out  registered one-cycle misprediction pulse
// ---------------------------------------------------------------------------
module branch_predict_unit
   import bp_pkg::*;
#(
   parameter int PC_W        = 32,
   parameter int BHT_ENTRIES = 64,
   parameter int CNT_W       = 2
)
(
   input  logic            clk,
   input  logic            rst,
   output logic            ready,
   input  logic            f_req,
   input  logic [PC_W-1:0] f_pc,
   output logic            f_pred_valid,
   output logic            f_pred_taken,
   input  logic            ex_valid,
   input  logic            ex_branch,
   input  logic [2:0]      ex_funct3,
   input  logic            ex_zero,
   input  logic [PC_W-1:0] ex_pc,
   input  logic            ex_pred_taken,
   output logic            ex_taken,
   output logic            ex_illegal,
   output logic            mispredict
`ifdef BRANCH_PREDICT_STATS_EN
   ,
   output logic [31:0]     stat_branches,
   output logic [31:0]     stat_mispredicts
`endif
);

   localparam int               IDX_W    = $clog2(BHT_ENTRIES);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(cnt_init_value(CNT_W));
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BHT_ENTRIES - 1);

   bp_state_t        state, state_next;
   logic [IDX_W-1:0] sweep, sweep_next;
   logic [CNT_W-1:0] bht [BHT_ENTRIES];

   logic [IDX_W-1:0] f_idx, ex_idx;
   logic             b, cond_taken, cond_illegal, resolved, do_update;

   // Only PC[IDX_W+1:2] selects a counter; the rest is deliberately ignored.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{f_pc[PC_W-1:IDX_W+2], f_pc[1:0],
                             ex_pc[PC_W-1:IDX_W+2], ex_pc[1:0]};

   assign f_idx  = f_pc[IDX_W+1:2];
   assign ex_idx = ex_pc[IDX_W+1:2];
   assign b      = ex_valid & ex_branch;

   branch_cond_eval u_cond (
      .b       (b),
      .funct3  (ex_funct3),
      .zero    (ex_zero),
      .taken   (cond_taken),
      .illegal (cond_illegal)
   );

   assign ex_taken   = cond_taken;
   assign ex_illegal = cond_illegal;
   assign resolved   = b & ~cond_illegal;
   assign do_update  = (state == RUN) & resolved;
   assign ready      = (state == RUN);

   // Sweep sequencing: INIT walks the index once and hands over to RUN
   // after the last entry has been written.
   always_comb begin
      state_next = state;
      sweep_next = sweep;
      if (state == INIT) begin
         sweep_next = sweep + 1'b1;
         if (sweep == LAST_IDX) begin
            state_next = RUN;
         end
      end
   end

   // State, lookup pipeline and mispredict registers. The lookup reads the
   // table before this edge's update lands, giving read-before-write.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= INIT;
         sweep        <= '0;
         f_pred_valid <= 1'b0;
         f_pred_taken <= 1'b0;
         mispredict   <= 1'b0;
      end else begin
         state        <= state_next;
         sweep        <= sweep_next;
         f_pred_valid <= f_req & (state == RUN);
         f_pred_taken <= f_req & (state == RUN) & bht[f_idx][CNT_W-1];
         mispredict   <= resolved & (cond_taken != ex_pred_taken);
      end
   end

   // Counter storage has no reset of its own; the INIT sweep is what
   // initialises it, so the array can map onto plain RAM/flops.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == INIT) begin
            bht[sweep] <= CNT_INIT;
         end else if (do_update) begin
            if (cond_taken && (bht[ex_idx] != CNT_MAX)) begin
               bht[ex_idx] <= bht[ex_idx] + 1'b1;
            end else if (!cond_taken && (bht[ex_idx] != '0)) begin
               bht[ex_idx] <= bht[ex_idx] - 1'b1;
            end
         end
      end
   end

`ifdef BRANCH_PREDICT_STATS_EN
   // Event counters stick at all-ones rather than wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else begin
         if (resolved && (stat_branches != 32'hFFFF_FFFF)) begin
            stat_branches <= stat_branches + 32'd1;
         end
         if (mispredict && (stat_mispredicts != 32'hFFFF_FFFF)) begin
            stat_mispredicts <= stat_mispredicts + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_predict_unit
// Drives directed scenarios and random traffic into branch_predict_unit and
// compares every output against a behavioural model kept as plain integers.
// ---------------------------------------------------------------------------
module tb_branch_predict_unit;

   localparam int N     = 64;
   localparam int CW    = 2;
   localparam int CMAX  = (1 << CW) - 1;
   localparam int CINIT = (1 << (CW - 1)) - 1;
   localparam int THR   = (1 << (CW - 1));

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ready;
   logic        f_req = 1'b0;
   logic [31:0] f_pc = '0;
   logic        f_pred_valid, f_pred_taken;
   logic        ex_valid = 1'b0, ex_branch = 1'b0, ex_zero = 1'b0;
   logic [2:0]  ex_funct3 = '0;
   logic [31:0] ex_pc = '0;
   logic        ex_pred_taken = 1'b0;
   logic        ex_taken, ex_illegal, mispredict;

   int n_vec  = 0;
   int n_miss = 0;

   int model_cnt [N];
   int model_sweep = 0;
   bit exp_pv, exp_pt, exp_misp, exp_ready, chk_pt;

   always #5 clk = ~clk;

   branch_predict_unit #(
      .PC_W        (32),
      .BHT_ENTRIES (N),
      .CNT_W       (CW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .ready         (ready),
      .f_req         (f_req),
      .f_pc          (f_pc),
      .f_pred_valid  (f_pred_valid),
      .f_pred_taken  (f_pred_taken),
      .ex_valid      (ex_valid),
      .ex_branch     (ex_branch),
      .ex_funct3     (ex_funct3),
      .ex_zero       (ex_zero),
      .ex_pc         (ex_pc),
      .ex_pred_taken (ex_pred_taken),
      .ex_taken      (ex_taken),
      .ex_illegal    (ex_illegal),
      .mispredict    (mispredict)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // One clock of stimulus: check the combinational resolution, advance the
   // model, then check the registered outputs after the edge.
   task automatic applyStimulus(input bit r, input bit fr, input logic [31:0] fpc,
                                input bit ev, input bit eb, input logic [2:0] f3,
                                input bit ez, input logic [31:0] epc, input bit ept);
      bit bb, ill, tk, run;
      int fi, ei;
      rst = r; f_req = fr; f_pc = fpc;
      ex_valid = ev; ex_branch = eb; ex_funct3 = f3; ex_zero = ez;
      ex_pc = epc; ex_pred_taken = ept;
      #1;
      bb  = ev && eb;
      ill = bb && (f3 == 3'd2 || f3 == 3'd3);
      if (f3 inside {3'd0, 3'd5, 3'd7})      tk = bb && ez;
      else if (f3 inside {3'd1, 3'd4, 3'd6}) tk = bb && !ez;
      else                                   tk = 1'b0;
      checkOutput("ex_taken", ex_taken, tk);
      checkOutput("ex_illegal", ex_illegal, ill);
      fi = int'((fpc >> 2) % N);
      ei = int'((epc >> 2) % N);
      if (r) begin
         for (int i = 0; i < N; i++) model_cnt[i] = CINIT;
         model_sweep = 0;
         exp_pv = 0; exp_pt = 0; exp_misp = 0; chk_pt = 1;
      end else begin
         run      = (model_sweep >= N);
         exp_misp = bb && !ill && (tk != ept);
         exp_pv   = fr && run;
         exp_pt   = exp_pv ? (model_cnt[fi] >= THR) : 1'b0;
         chk_pt   = exp_pv || !run;
         if (run && bb && !ill) begin
            if (tk && model_cnt[ei] < CMAX)      model_cnt[ei]++;
            else if (!tk && model_cnt[ei] > 0)   model_cnt[ei]--;
         end
         if (!run) model_sweep++;
      end
      exp_ready = (model_sweep >= N);
      @(posedge clk);
      @(negedge clk);
      checkOutput("ready", ready, exp_ready);
      checkOutput("f_pred_valid", f_pred_valid, exp_pv);
      checkOutput("mispredict", mispredict, exp_misp);
      if (chk_pt) checkOutput("f_pred_taken", f_pred_taken, exp_pt);
   endtask

   function automatic logic [31:0] rand_pc();
      logic [31:0] p;
      p = ($urandom & 32'hFFFF_FF00) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      return p;
   endfunction

   task automatic randomCycle(input bit allow_rst);
      bit r;
      r = allow_rst && ($urandom_range(0, 99) == 0);
      applyStimulus(r, 1'($urandom), rand_pc(), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 3) != 0), 3'($urandom), 1'($urandom),
                    rand_pc(), 1'($urandom));
   endtask

   task automatic idle(input int n, input bit r);
      for (int i = 0; i < n; i++) applyStimulus(r, 0, 32'h0, 0, 0, 3'd0, 0, 32'h0, 0);
   endtask

   initial begin
      // Reset, then random traffic through the whole INIT sweep.
      idle(2, 1'b1);
      for (int i = 0; i < N; i++) randomCycle(1'b0);
      checkOutput("plan_ready_after_sweep", ready, 1);

      // Fresh entry at 0x100 is weakly not taken.
      applyStimulus(0, 1, 32'h100, 0, 0, 3'd0, 0, 32'h0, 0);
      checkOutput("plan_lookup_100_init", f_pred_taken, 0);

      // Mispredicted BEQ at 0x100 trains 01 -> 10.
      applyStimulus(0, 0, 32'h0, 1, 1, 3'd0, 1, 32'h100, 0);
      checkOutput("plan_beq_misp", mispredict, 1);
      idle(1, 1'b0);
      checkOutput("plan_misp_one_cycle", mispredict, 0);
      applyStimulus(0, 1, 32'h100, 0, 0, 3'd0, 0, 32'h0, 0);
      checkOutput("plan_lookup_100_trained", f_pred_taken, 1);

      // Saturation at 0x40, then one not-taken step.
      for (int i = 0; i < 4; i++) applyStimulus(0, 0, 32'h0, 1, 1, 3'd0, 1, 32'h40, 1);
      applyStimulus(0, 0, 32'h0, 1, 1, 3'd1, 1, 32'h40, 1);
      applyStimulus(0, 1, 32'h40, 0, 0, 3'd0, 0, 32'h0, 0);
      checkOutput("plan_lookup_40_after_nt", f_pred_taken, 1);

      // Illegal funct3 leaves state alone and never mispredicts.
      applyStimulus(0, 0, 32'h0, 1, 1, 3'd2, 0, 32'h40, 1);
      checkOutput("plan_illegal_no_misp", mispredict, 0);

      // Same-cycle lookup and update at 0x80: read-before-write.
      applyStimulus(0, 1, 32'h80, 1, 1, 3'd0, 1, 32'h80, 0);
      checkOutput("plan_rbw_old", f_pred_taken, 0);
      applyStimulus(0, 1, 32'h80, 0, 0, 3'd0, 0, 32'h0, 0);
      checkOutput("plan_rbw_new", f_pred_taken, 1);

      // Random traffic in RUN with occasional resets.
      for (int i = 0; i < 400; i++) randomCycle(1'b1);

      // Reset mid-sweep, then reset on top of a pending mispredict.
      idle(1, 1'b1);
      for (int i = 0; i < 30; i++) randomCycle(1'b0);
      applyStimulus(1, 0, 32'h0, 1, 1, 3'd0, 1, 32'h100, 0);
      checkOutput("plan_rst_clears_misp", mispredict, 0);
      checkOutput("plan_rst_ready", ready, 0);
      for (int i = 0; i < N - 1; i++) randomCycle(1'b0);
      checkOutput("plan_sweep_63", ready, 0);
      randomCycle(1'b0);
      checkOutput("plan_sweep_64", ready, 1);
      for (int i = 0; i < 100; i++) randomCycle(1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor to the core's combinational branch decision logic.
- Resolves RV32 conditional branches in EX from funct3 and the ALU zero flag.
- Adds a branch history table (BHT) of saturating counters, indexed by PC, for fetch-stage prediction.
- Flags mispredictions one cycle after resolution and trains the table.
- Sits between IF (lookup) and EX (resolve/update); its mispredict output drives the pipeline flush/redirect.

Parameters:
- PC_W, 32, PC width in bits.
- BHT_ENTRIES, 64, number of counters; power of 2, ≥ 2.
- CNT_W, 2, saturating counter width; ≥ 1.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- ready  out  1  table initialised; predictions valid
- f_req  in  1  fetch lookup request
- f_pc  in  PC_W  fetch PC
- f_pred_valid  out  1  f_pred_taken is valid this cycle
- f_pred_taken  out  1  predicted direction
- ex_valid  in  1  EX stage holds a valid instruction
- ex_branch  in  1  instruction is a conditional branch
- ex_funct3  in  3  branch funct3
- ex_zero  in  1  ALU zero flag from the compare
- ex_pc  in  PC_W  PC of the EX instruction
- ex_pred_taken  in  1  prediction carried down the pipe with the instruction
- ex_taken  out  1  resolved direction (combinational)
- ex_illegal  out  1  branch with unsupported funct3 (combinational)
- mispredict  out  1  registered misprediction pulse

Behaviour:
- Index: idx = pc[log2(BHT_ENTRIES)+1:2].
- Predicted taken when counter MSB = 1.
- Resolution (combinational), with b = ex_valid & ex_branch:
  - funct3 000/101/111: ex_taken = b & zero
  - funct3 001/100/110: ex_taken = b & ~zero
  - funct3 010/011: ex_taken = 0 and ex_illegal = b
- mispredict is registered: next cycle = b & ~ex_illegal & (ex_taken != ex_pred_taken). It is a 1-cycle pulse per offending branch.
- FSM states INIT and RUN.
  - rst → INIT with sweep index 0.
  - INIT writes weakly-not-taken (value 2^(CNT_W-1) - 1; 01 for CNT_W = 2) to one entry per cycle.
  - INIT moves to RUN after entry BHT_ENTRIES-1 is written, i.e. BHT_ENTRIES cycles after rst deasserts.
  - ready = 1 only in RUN.
- Lookup latency is 1 cycle: f_pred_valid(t+1) = f_req(t) & RUN(t), and f_pred_taken is the registered MSB.
  - In INIT, f_pred_valid = 0 and f_pred_taken = 0.
- Update happens at the clock edge when RUN & b & ~ex_illegal.
  - Counter at idx(ex_pc) saturating-increments if ex_taken, otherwise decrements.
  - No wrap at 0 or at 2^CNT_W - 1.
- Lookup and update to the same index in the same cycle: the lookup returns the pre-update value (read-before-write).
- Updates during INIT are dropped. Resolution and mispredict still operate.
- Reset values: ready = 0, f_pred_valid = 0, f_pred_taken = 0, mispredict = 0, state = INIT.
- Reset mid-operation: any pending mispredict is cleared, the FSM returns to INIT, and the sweep restarts at 0.

Optional Feature:
- Macro: BRANCH_PREDICT_STATS_EN.
- When defined:
  - Adds outputs stat_branches[31:0] and stat_mispredicts[31:0].
  - stat_branches increments once per cycle in which b & ~ex_illegal.
  - stat_mispredicts increments on each mispredict pulse.
  - Both saturate at 0xFFFFFFFF and clear on rst.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package bp_pkg holds:
  - funct3 constants F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU
  - the state enum bp_state_t {INIT, RUN}
  - the function for the counter initial value
- Sub-module branch_cond_eval holds the pure combinational funct3/zero → taken/illegal decision, reused by the top level.

Test Plan:
- Reset, BHT_ENTRIES = 64 → ready = 0 for 64 cycles then 1. Lookup f_pc = 0x100 → f_pred_valid = 1 and f_pred_taken = 0 next cycle.
- BEQ (000), zero = 1, ex_pred_taken = 0 → ex_taken = 1, mispredict = 1 for exactly one cycle. Repeat with ex_pc = 0x100 → a lookup of 0x100 predicts taken after the first update (01 → 10).
- Four consecutive taken updates at ex_pc = 0x40 → counter saturates at 11. One not-taken update → 10, still predicted taken.
- funct3 = 010 with b = 1 → ex_taken = 0, ex_illegal = 1, no mispredict, counter unchanged.
- Same-cycle f_pc = ex_pc = 0x80 with taken update from 01 → lookup returns 0; the next lookup returns 1.
- rst asserted mid-sweep (cycle 30) and during a pending mispredict → mispredict = 0, ready = 0, and the sweep restarts and takes 64 more cycles.
